// File: rtl/demux_rr_sched_if.sv
// Handshake and demux-side signal bundle for the round-robin demux scheduler.
// master: the scheduler. slave: the source, requesters and demux around it.
interface demux_rr_sched_if;
    logic [3:0] req;
    logic       src_valid;
    logic       src_bit;
    logic       src_ready;
    logic [1:0] s;
    logic       i;
    logic       i_vld;
    logic [3:0] gnt;
    logic       busy;
    logic       done;

    modport master (
        input  req, src_valid, src_bit,
        output src_ready, s, i, i_vld, gnt, busy, done
    );

    modport slave (
        output req, src_valid, src_bit,
        input  src_ready, s, i, i_vld, gnt, busy, done
    );
endinterface

// File: rtl/demux_rr_sched.sv
// Round-robin scheduler that grants one of four sinks, holds the 1-to-4 demux
// select on it and streams exactly LEN serial bits from a valid/ready source.
module demux_rr_sched #(
    parameter int unsigned LEN = 8,
    parameter int unsigned CW  = 8
) (
    input logic              clk,
    input logic              rst_n,
    demux_rr_sched_if.master bus
);

    typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

    state_e          state_q, state_d;
    logic [1:0]      s_q, s_d;
    logic            i_q, i_d;
    logic            i_vld_q, i_vld_d;
    logic [3:0]      gnt_q, gnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [1:0]      winner;
    logic            found;

    // Arbitration: first set req bit scanning ptr+1, ptr+2, ptr+3, ptr (mod 4).
    always_comb begin
        winner = ptr_q;
        found  = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!found && bus.req[ptr_q + 2'(k)]) begin
                winner = ptr_q + 2'(k);
                found  = 1'b1;
            end
        end
    end

    // Next-state and registered-output decode; i/i_vld/done are pulses by default.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        gnt_d   = gnt_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        i_d     = 1'b0;
        i_vld_d = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|bus.req) begin
                    s_d     = winner;
                    gnt_d   = 4'b0001 << winner;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = StXfer;
                end
            end
            StXfer: begin
                if (bus.src_valid) begin
                    i_d     = bus.src_bit;
                    i_vld_d = 1'b1;
                    // Counter stops at LEN-1 so it never needs to hold LEN.
                    if (cnt_q == CW'(LEN - 1)) begin
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            StDone: begin
                done_d  = 1'b1;
                gnt_d   = '0;
                busy_d  = 1'b0;
                ptr_d   = s_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; async reset drops any partial transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            s_q     <= 2'b00;
            i_q     <= 1'b0;
            i_vld_q <= 1'b0;
            gnt_q   <= 4'b0000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            ptr_q   <= 2'd3;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            i_q     <= i_d;
            i_vld_q <= i_vld_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.src_ready = (state_q == StXfer);
    assign bus.s         = s_q;
    assign bus.i         = i_q;
    assign bus.i_vld     = i_vld_q;
    assign bus.gnt       = gnt_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_demux_rr_sched.sv
// Directed bench for demux_rr_sched: a cycle table for reset, a plain transfer
// and a stalled transfer, then hand sequences for arbitration and reset cases.
module tb_demux_rr_sched;

    localparam int unsigned LEN = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    demux_rr_sched_if bus ();

    demux_rr_sched #(.LEN(LEN), .CW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       v;
        logic       b;
        logic [1:0] s;
        logic       i;
        logic       iv;
        logic [3:0] gnt;
        logic       busy;
        logic       done;
        logic       rdy;
    } vec_t;

    vec_t tbl[$];
    logic expq[$];
    int   nvec = 0;
    int   nfail = 0;
    int   nvld = 0;
    int   ndone = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic row(input logic rst, input logic [3:0] req, input logic v, input logic b,
                       input logic [1:0] s, input logic i, input logic iv, input logic [3:0] gnt,
                       input logic busy, input logic done, input logic rdy);
        vec_t t;
        t.rst = rst; t.req = req; t.v = v; t.b = b;
        t.s = s; t.i = i; t.iv = iv; t.gnt = gnt; t.busy = busy; t.done = done; t.rdy = rdy;
        tbl.push_back(t);
    endtask

    // One clock; afterwards checks forwarded bits against the expected queue.
    task automatic step();
        logic b;
        @(posedge clk);
        #1;
        if (mon_en) begin
            if (bus.i_vld) begin
                chk("ivld_has_pending_bit", 32'(expq.size() != 0), 32'd1);
                if (expq.size() != 0) begin
                    b = expq.pop_front();
                    chk("i_bit", 32'(bus.i), 32'(b));
                end
                nvld++;
            end
            if (bus.done) ndone++;
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_s"}, 32'(bus.s), 32'd0);
        chk({nm, "_i"}, 32'(bus.i), 32'd0);
        chk({nm, "_ivld"}, 32'(bus.i_vld), 32'd0);
        chk({nm, "_gnt"}, 32'(bus.gnt), 32'd0);
        chk({nm, "_busy"}, 32'(bus.busy), 32'd0);
        chk({nm, "_done"}, 32'(bus.done), 32'd0);
        chk({nm, "_rdy"}, 32'(bus.src_ready), 32'd0);
    endtask

    // Full transfer: wait for grant, send LEN random bits, wait for done.
    task automatic xfer(input logic [3:0] r, input logic [1:0] es, input int mid_at,
                        input logic [3:0] r_mid, input string nm);
        int n;
        logic b;
        bus.req = r;
        bus.src_valid = 1'b0;
        nvld = 0;
        ndone = 0;
        n = 0;
        while (!bus.src_ready && n < 8) begin
            step();
            n++;
        end
        chk({nm, "_ready"}, 32'(bus.src_ready), 32'd1);
        chk({nm, "_s"}, 32'(bus.s), 32'(es));
        chk({nm, "_gnt"}, 32'(bus.gnt), 32'(4'b0001 << es));
        chk({nm, "_busy"}, 32'(bus.busy), 32'd1);
        for (int k = 0; k < int'(LEN); k++) begin
            if (k == mid_at) bus.req = r_mid;
            b = 1'($urandom_range(0, 1));
            bus.src_valid = 1'b1;
            bus.src_bit = b;
            expq.push_back(b);
            step();
            chk({nm, "_s_frozen"}, 32'(bus.s), 32'(es));
        end
        bus.src_valid = 1'b0;
        n = 0;
        while (ndone == 0 && n < 6) begin
            step();
            n++;
        end
        chk({nm, "_done_cnt"}, 32'(ndone), 32'd1);
        chk({nm, "_ivld_cnt"}, 32'(nvld), 32'(LEN));
        chk({nm, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        chk({nm, "_gnt_at_done"}, 32'(bus.gnt), 32'd0);
        chk({nm, "_s_at_done"}, 32'(bus.s), 32'(es));
    endtask

    task automatic do_reset();
        bus.req = '0;
        bus.src_valid = 1'b0;
        bus.src_bit = 1'b0;
        rst_n = 1'b0;
        step();
        expq.delete();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] order[$];
        bus.req = '0;
        bus.src_valid = 1'b0;
        bus.src_bit = 1'b0;

        // rst, req, v, b | s, i, iv, gnt, busy, done, rdy
        row(0, 4'h0, 0, 0, 2'd0, 0, 0, 4'h0, 0, 0, 0);
        row(0, 4'h0, 0, 0, 2'd0, 0, 0, 4'h0, 0, 0, 0);
        for (int k = 0; k < 5; k++) row(1, 4'h0, 0, 0, 2'd0, 0, 0, 4'h0, 0, 0, 0);
        // Plain transfer to sink 2, bits 1,0,1,1,0,0,1,0.
        row(1, 4'h4, 0, 0, 2'd0, 0, 0, 4'h0, 0, 0, 0);
        row(1, 4'h4, 1, 1, 2'd2, 0, 0, 4'h4, 1, 0, 1);
        row(1, 4'h4, 1, 0, 2'd2, 1, 1, 4'h4, 1, 0, 1);
        row(1, 4'h4, 1, 1, 2'd2, 0, 1, 4'h4, 1, 0, 1);
        row(1, 4'h4, 1, 1, 2'd2, 1, 1, 4'h4, 1, 0, 1);
        row(1, 4'h4, 1, 0, 2'd2, 1, 1, 4'h4, 1, 0, 1);
        row(1, 4'h4, 1, 0, 2'd2, 0, 1, 4'h4, 1, 0, 1);
        row(1, 4'h4, 1, 1, 2'd2, 0, 1, 4'h4, 1, 0, 1);
        row(1, 4'h4, 1, 0, 2'd2, 1, 1, 4'h4, 1, 0, 1);
        row(1, 4'h0, 0, 0, 2'd2, 0, 1, 4'h4, 1, 0, 0);
        row(1, 4'h0, 0, 0, 2'd2, 0, 0, 4'h0, 0, 1, 0);
        row(1, 4'h0, 0, 0, 2'd2, 0, 0, 4'h0, 0, 0, 0);
        // Same transfer with src_valid toggling; stall cycles drive src_bit=1.
        row(1, 4'h4, 0, 0, 2'd2, 0, 0, 4'h0, 0, 0, 0);
        row(1, 4'h4, 1, 1, 2'd2, 0, 0, 4'h4, 1, 0, 1);
        row(1, 4'h4, 0, 1, 2'd2, 1, 1, 4'h4, 1, 0, 1);
        row(1, 4'h4, 1, 0, 2'd2, 0, 0, 4'h4, 1, 0, 1);
        row(1, 4'h4, 0, 1, 2'd2, 0, 1, 4'h4, 1, 0, 1);
        row(1, 4'h4, 1, 1, 2'd2, 0, 0, 4'h4, 1, 0, 1);
        row(1, 4'h4, 0, 1, 2'd2, 1, 1, 4'h4, 1, 0, 1);
        row(1, 4'h4, 1, 1, 2'd2, 0, 0, 4'h4, 1, 0, 1);
        row(1, 4'h4, 0, 1, 2'd2, 1, 1, 4'h4, 1, 0, 1);
        row(1, 4'h4, 1, 0, 2'd2, 0, 0, 4'h4, 1, 0, 1);
        row(1, 4'h4, 0, 1, 2'd2, 0, 1, 4'h4, 1, 0, 1);
        row(1, 4'h4, 1, 0, 2'd2, 0, 0, 4'h4, 1, 0, 1);
        row(1, 4'h4, 0, 1, 2'd2, 0, 1, 4'h4, 1, 0, 1);
        row(1, 4'h4, 1, 1, 2'd2, 0, 0, 4'h4, 1, 0, 1);
        row(1, 4'h4, 0, 1, 2'd2, 1, 1, 4'h4, 1, 0, 1);
        row(1, 4'h4, 1, 0, 2'd2, 0, 0, 4'h4, 1, 0, 1);
        row(1, 4'h0, 0, 0, 2'd2, 0, 1, 4'h4, 1, 0, 0);
        row(1, 4'h0, 0, 0, 2'd2, 0, 0, 4'h0, 0, 1, 0);
        row(1, 4'h0, 0, 0, 2'd2, 0, 0, 4'h0, 0, 0, 0);

        foreach (tbl[k]) begin
            rst_n = tbl[k].rst;
            bus.req = tbl[k].req;
            bus.src_valid = tbl[k].v;
            bus.src_bit = tbl[k].b;
            #1;
            chk($sformatf("row%0d_s", k), 32'(bus.s), 32'(tbl[k].s));
            chk($sformatf("row%0d_i", k), 32'(bus.i), 32'(tbl[k].i));
            chk($sformatf("row%0d_ivld", k), 32'(bus.i_vld), 32'(tbl[k].iv));
            chk($sformatf("row%0d_gnt", k), 32'(bus.gnt), 32'(tbl[k].gnt));
            chk($sformatf("row%0d_busy", k), 32'(bus.busy), 32'(tbl[k].busy));
            chk($sformatf("row%0d_done", k), 32'(bus.done), 32'(tbl[k].done));
            chk($sformatf("row%0d_rdy", k), 32'(bus.src_ready), 32'(tbl[k].rdy));
            @(posedge clk);
            #1;
        end

        mon_en = 1'b1;

        // Fairness: all four requesting, then 1010 starting from ptr=0.
        do_reset();
        order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        foreach (order[k]) xfer(4'b1111, order[k], 99, 4'b1111, $sformatf("rr_all%0d", k));
        order = '{2'd1, 2'd3, 2'd1};
        foreach (order[k]) xfer(4'b1010, order[k], 99, 4'b1010, $sformatf("rr_1010_%0d", k));

        // Granted req dropped after 2 bits while sink 3 starts requesting.
        xfer(4'b0001, 2'd0, 2, 4'b1000, "drop");
        step();
        chk("late_s", 32'(bus.s), 32'd3);
        chk("late_gnt", 32'(bus.gnt), 32'h8);
        chk("late_rdy", 32'(bus.src_ready), 32'd1);
        xfer(4'b1000, 2'd3, 99, 4'b1000, "late");

        // Reset after 3 bits of a sink-1 transfer.
        do_reset();
        bus.req = 4'b0010;
        ndone = 0;
        step();
        chk("mid_s", 32'(bus.s), 32'd1);
        chk("mid_gnt", 32'(bus.gnt), 32'h2);
        for (int k = 0; k < 3; k++) begin
            logic b;
            b = 1'($urandom_range(0, 1));
            bus.src_valid = 1'b1;
            bus.src_bit = b;
            expq.push_back(b);
            step();
        end
        chk("mid_busy_before", 32'(bus.busy), 32'd1);
        bus.src_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        expq.delete();
        step();
        chk_reset_vals("mid_rst_hold");
        rst_n = 1'b1;
        bus.req = 4'b0011;
        step();
        chk("post_rst_s", 32'(bus.s), 32'd0);
        chk("post_rst_gnt", 32'(bus.gnt), 32'h1);
        chk("post_rst_no_done", 32'(ndone), 32'd0);
        xfer(4'b0011, 2'd0, 99, 4'b0011, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
